// File: rtl/prescaler_pkg.sv
// rtl/prescaler_pkg.sv - shared mode and one-shot state encodings for prog_prescaler
package prescaler_pkg;

  localparam logic [1:0] MODE_PERIODIC = 2'b00;
  localparam logic [1:0] MODE_SQUARE   = 2'b01;
  localparam logic [1:0] MODE_ONESHOT  = 2'b10;

  typedef enum logic {
    OS_IDLE = 1'b0,
    OS_RUN  = 1'b1
  } os_state_t;

endpackage

// File: rtl/prescaler_tc_counter.sv
// rtl/prescaler_tc_counter.sv - WIDTH-bit up counter with clear, enable and terminal-count compare
module prescaler_tc_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] tc,
  output logic [WIDTH-1:0] cnt,
  output logic             tc_hit
);

  assign tc_hit = (cnt == tc);

  // count up to tc then restart at 0; clear has priority over enable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc_hit ? '0 : cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/prog_prescaler.sv
// rtl/prog_prescaler.sv - programmable prescaler (tick / square / one-shot); one-shot built when PRESCALER_ONESHOT_EN is defined
module prog_prescaler
  import prescaler_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_value,
  input  logic [1:0]       mode,
  input  logic             start,
  output logic             tick,
  output logic             sq_out,
  output logic             busy,
  output logic [WIDTH-1:0] cnt_out
);

  logic [1:0]       mode_q;
  logic [WIDTH-1:0] tc_q;
  logic             mode_chg;
  logic             os_idle;
  logic             tc_hit;
  logic             term;
  logic             cnt_clear;
  logic             cnt_en;

  // a mode change restarts everything; the new mode only takes effect next cycle
  assign mode_chg  = (mode != mode_q);
  // a load or mode change suppresses a coincident terminal count
  assign term      = en & ~mode_chg & ~div_load & ~os_idle & tc_hit;
  // an idle one-shot keeps the counter parked at 0
  assign cnt_clear = mode_chg | div_load | (en & os_idle);
  assign cnt_en    = en & ~os_idle;

  prescaler_tc_counter #(.WIDTH(WIDTH)) u_counter (
    .clk    (clk),
    .reset  (reset),
    .en     (cnt_en),
    .clear  (cnt_clear),
    .tc     (tc_q),
    .cnt    (cnt_out),
    .tc_hit (tc_hit)
  );

  // mode, terminal count, tick and square-wave registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q <= MODE_PERIODIC;
      tc_q   <= WIDTH'(DEFAULT_DIV);
      tick   <= 1'b0;
      sq_out <= 1'b0;
    end else begin
      mode_q <= mode;
      if (div_load) tc_q <= div_value;
      tick <= term;
      if (mode_chg) begin
        sq_out <= 1'b0;
      end else if (term && mode_q == MODE_SQUARE) begin
        sq_out <= ~sq_out;
      end
    end
  end

`ifdef PRESCALER_ONESHOT_EN
  os_state_t os_state;
  os_state_t os_next;
  logic      os_act;

  assign os_act = (mode_q == MODE_ONESHOT);

  // one-shot state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) os_state <= OS_IDLE;
    else        os_state <= os_next;
  end

  // one-shot next state: start arms from idle, terminal count returns to idle
  always_comb begin
    os_next = os_state;
    if (mode_chg) begin
      os_next = OS_IDLE;
    end else if (os_act && en) begin
      case (os_state)
        OS_IDLE: if (start) os_next = OS_RUN;
        OS_RUN:  if (term)  os_next = OS_IDLE;
        default: os_next = OS_IDLE;
      endcase
    end
  end

  // one-shot outputs decoded from the state register
  always_comb begin
    os_idle = os_act && (os_state == OS_IDLE);
    busy    = (os_state == OS_RUN);
  end
`else
  logic unused_start;
  assign unused_start = start;
  assign os_idle      = 1'b0;
  assign busy         = 1'b0;
`endif

endmodule

// File: tb/tb_prog_prescaler.sv
// tb/tb_prog_prescaler.sv - scoreboard bench for prog_prescaler
module tb_prog_prescaler;

  localparam int WIDTH = 8;
  localparam int DDIV  = 1;

  logic             clk;
  logic             reset;
  logic             en;
  logic             div_load;
  logic [WIDTH-1:0] div_value;
  logic [1:0]       mode;
  logic             start;
  logic             tick;
  logic             sq_out;
  logic             busy;
  logic [WIDTH-1:0] cnt_out;

  prog_prescaler #(.WIDTH(WIDTH), .DEFAULT_DIV(DDIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .div_load  (div_load),
    .div_value (div_value),
    .mode      (mode),
    .start     (start),
    .tick      (tick),
    .sq_out    (sq_out),
    .busy      (busy),
    .cnt_out   (cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int tick;
    int sq;
    int busy;
  } exp_t;

  exp_t sb[$];

  int n_pass  = 0;
  int n_total = 0;

  int m_cnt, m_tick, m_sq, m_tc, m_run;
  logic [1:0] m_mode;

  task automatic chk(input string tag, input int obs, input int expv);
    n_total++;
    if (obs == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
  endtask

  task automatic model_reset();
    m_cnt = 0; m_tick = 0; m_sq = 0; m_run = 0; m_tc = DDIV; m_mode = 2'b00;
  endtask

  // reference behaviour for one clock edge, from the currently driven inputs
  task automatic model_edge();
    bit os;
`ifdef PRESCALER_ONESHOT_EN
    os = (m_mode == 2'b10);
`else
    os = 1'b0;
`endif
    if (mode != m_mode) begin
      m_mode = mode;
      if (div_load) m_tc = int'(div_value);
      m_cnt = 0; m_tick = 0; m_sq = 0; m_run = 0;
    end else if (div_load) begin
      m_tc = int'(div_value);
      m_cnt = 0; m_tick = 0;
      if (os && en && !m_run && start) m_run = 1;
    end else if (!en) begin
      m_tick = 0;
    end else if (os && !m_run) begin
      m_cnt = 0; m_tick = 0;
      if (start) m_run = 1;
    end else if (m_cnt == m_tc) begin
      m_cnt = 0; m_tick = 1;
      if (os) m_run = 0;
      if (m_mode == 2'b01) m_sq = 1 - m_sq;
    end else begin
      m_cnt = (m_cnt + 1) % (1 << WIDTH);
      m_tick = 0;
    end
  endtask

  task automatic step();
    exp_t e;
    model_edge();
    e = '{m_cnt, m_tick, m_sq, m_run};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("cnt_out", int'(cnt_out), e.cnt);
    chk("tick", int'(tick), e.tick);
    chk("sq_out", int'(sq_out), e.sq);
    chk("busy", int'(busy), e.busy);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load(input int v);
    div_load = 1'b1; div_value = WIDTH'(v);
    step();
    div_load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; en = 1'b1; div_load = 1'b0; div_value = '0; mode = 2'b00; start = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cnt", int'(cnt_out), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_sq", int'(sq_out), 0);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b1;

    // default divider, periodic
    steps(6);

    // load TC=4 while cnt_out=1
    for (int i = 0; i < 4 && m_cnt != 1; i++) step();
    chk("pre_load_cnt", int'(cnt_out), 1);
    load(4);
    steps(12);

    // square mode TC=2 with an enable gap mid-period
    load(2);
    mode = 2'b01;
    steps(8);
    en = 1'b0;
    steps(4);
    en = 1'b1;
    steps(10);

    // one-shot TC=3, retrigger during busy, then load coincident with start
    mode = 2'b10;
    step();
    load(3);
    steps(2);
    start = 1'b1; step(); start = 1'b0;
    steps(2);
    start = 1'b1; step(); start = 1'b0;
    steps(6);
    start = 1'b1; div_load = 1'b1; div_value = WIDTH'(2);
    step();
    start = 1'b0; div_load = 1'b0;
    steps(5);

    // TC=0 square, then back to periodic
    mode = 2'b01;
    load(0);
    steps(4);
    mode = 2'b00;
    steps(3);

    // async reset mid-count at cnt_out=3
    load(5);
    for (int i = 0; i < 10 && m_cnt != 3; i++) step();
    chk("pre_rst_cnt", int'(cnt_out), 3);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_cnt", int'(cnt_out), 0);
    chk("arst_tick", int'(tick), 0);
    chk("arst_sq", int'(sq_out), 0);
    chk("arst_busy", int'(busy), 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    steps(6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
